// File: rtl/req_encoder_16to4_if.sv
// Request/grant bundle between the event sources, the consumer and the 16-to-4 encoder.
interface req_encoder_16to4_if;
  logic [15:0] req;
  logic [15:0] mask;
  logic        ack;
  logic [3:0]  code;
  logic        valid;
  logic [15:0] pending;
  logic        overrun;

  modport master (
    output req, mask, ack,
    input  code, valid, pending, overrun
  );

  modport slave (
    input  req, mask, ack,
    output code, valid, pending, overrun
  );
endinterface

// File: rtl/req_encoder_16to4.sv
// 16-to-4 request encoder: edge-captures 16 request lines into sticky pending
// bits, arbitrates (fixed or round-robin) and offers one code at a time with a
// valid/ack handshake. Used as the CPU event/interrupt encoder.
module req_encoder_16to4 #(
  parameter bit ROUND_ROBIN = 1'b0
) (
  input logic               clk,
  input logic               rst_n,
  req_encoder_16to4_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [15:0] req_q;
  logic [15:0] pending_r;
  logic [15:0] rise;
  logic [15:0] clr;
  logic [15:0] elig;
  logic [3:0]  code_r;
  logic [3:0]  last_grant;
  logic [3:0]  sel;
  logic        overrun_r;
  logic        valid_c;
  logic        fire;

  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    onehot16 = 16'h0001 << idx;
  endfunction

  // Lowest set index wins.
  function automatic logic [3:0] sel_fixed(input logic [15:0] e);
    sel_fixed = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (e[i]) sel_fixed = 4'(i);
    end
  endfunction

  // First set index scanning lg+1 upward, wrapping modulo 16 back to lg.
  function automatic logic [3:0] sel_rr(input logic [15:0] e, input logic [3:0] lg);
    logic [3:0] idx;
    logic       found;
    sel_rr = 4'd0;
    found  = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      idx = lg + 4'(i);
      if (!found && e[idx]) begin
        sel_rr = idx;
        found  = 1'b1;
      end
    end
  endfunction

  assign rise = bus.req & ~req_q;
  assign fire = valid_c & bus.ack;
  assign clr  = fire ? onehot16(code_r) : 16'h0000;
  assign elig = pending_r & ~bus.mask;
  assign sel  = ROUND_ROBIN ? sel_rr(elig, last_grant) : sel_fixed(elig);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: offer when anything is eligible, return to IDLE on ack.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (elig != 16'h0000) state_nxt = OFFER;
      OFFER:   if (bus.ack)          state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: valid is asserted for exactly the OFFER state.
  always_comb begin
    valid_c = (state == OFFER);
  end

  // Edge capture into sticky pending bits; a new rise beats the ack clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q     <= 16'h0000;
      pending_r <= 16'h0000;
      overrun_r <= 1'b0;
    end else begin
      req_q     <= bus.req;
      pending_r <= (pending_r & ~clr) | rise;
      overrun_r <= |(rise & pending_r & ~clr);
    end
  end

  // Latch the offered code on entry to OFFER; remember the last accepted grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_r     <= 4'd0;
      last_grant <= 4'd15;
    end else begin
      if (state == IDLE && elig != 16'h0000) code_r <= sel;
      if (fire) last_grant <= code_r;
    end
  end

  assign bus.code    = code_r;
  assign bus.valid   = valid_c;
  assign bus.pending = pending_r;
  assign bus.overrun = overrun_r;

endmodule

// File: tb/tb_req_encoder_16to4.sv
// Bench for req_encoder_16to4: one fixed-priority and one round-robin instance.
// Expected grant codes are queued by the stimulus; a monitor pops them on each handshake.
module tb_req_encoder_16to4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  logic [3:0] q_f [$];
  logic [3:0] q_r [$];
  logic [3:0] e_f;
  logic [3:0] e_r;
  logic [3:0] t2_code [4];

  req_encoder_16to4_if f_if ();
  req_encoder_16to4_if r_if ();

  req_encoder_16to4 #(.ROUND_ROBIN(1'b0)) dut_fixed (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (f_if.slave)
  );

  req_encoder_16to4 #(.ROUND_ROBIN(1'b1)) dut_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (r_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted handshake must match the next queued code.
  always @(negedge clk) begin
    if (rst_n && f_if.valid && f_if.ack) begin
      if (q_f.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL fixed_grant: got code %0d, expected no grant", f_if.code);
      end else begin
        e_f = q_f.pop_front();
        chk("fixed_grant", 32'(f_if.code), 32'(e_f));
      end
    end
    if (rst_n && r_if.valid && r_if.ack) begin
      if (q_r.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rr_grant: got code %0d, expected no grant", r_if.code);
      end else begin
        e_r = q_r.pop_front();
        chk("rr_grant", 32'(r_if.code), 32'(e_r));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    t2_code = '{4'd0, 4'd5, 4'd10, 4'd15};
    rst_n = 1'b0;
    f_if.req = 16'h0; f_if.mask = 16'h0; f_if.ack = 1'b0;
    r_if.req = 16'h0; r_if.mask = 16'h0; r_if.ack = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_valid",   32'(f_if.valid),   32'h0);
    chk("rst_code",    32'(f_if.code),    32'h0);
    chk("rst_pending", 32'(f_if.pending), 32'h0);
    chk("rst_overrun", 32'(f_if.overrun), 32'h0);

    // Test 1: single request on bit 3
    f_if.req = 16'h0008;
    q_f.push_back(4'd3);
    tick();
    chk("t1_pending", 32'(f_if.pending), 32'h0008);
    chk("t1_valid0",  32'(f_if.valid),   32'h0);
    tick();
    chk("t1_valid1",  32'(f_if.valid),   32'h1);
    chk("t1_code",    32'(f_if.code),    32'd3);
    f_if.ack = 1'b1;
    tick();
    chk("t1_ack_valid",   32'(f_if.valid),   32'h0);
    chk("t1_ack_pending", 32'(f_if.pending), 32'h0);
    f_if.ack = 1'b0;
    f_if.req = 16'h0;
    tick();

    // Test 2: four simultaneous requests, ack held high
    f_if.req = 16'h8421;
    f_if.ack = 1'b1;
    for (int i = 0; i < 4; i++) q_f.push_back(t2_code[i]);
    tick();
    f_if.req = 16'h0;
    chk("t2_pending", 32'(f_if.pending), 32'h8421);
    chk("t2_valid0",  32'(f_if.valid),   32'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t2_valid_pattern", 32'(f_if.valid), ((i % 2) == 0) ? 32'h1 : 32'h0);
      if ((i % 2) == 0) chk("t2_code", 32'(f_if.code), 32'(t2_code[i / 2]));
    end
    chk("t2_pending_end", 32'(f_if.pending), 32'h0);
    f_if.ack = 1'b0;
    tick();

    // Test 4: masked bit 0, then unmask
    f_if.mask = 16'h0001;
    f_if.req  = 16'h0003;
    q_f.push_back(4'd1);
    q_f.push_back(4'd0);
    tick();
    tick();
    chk("t4_valid", 32'(f_if.valid), 32'h1);
    chk("t4_code",  32'(f_if.code),  32'd1);
    f_if.mask = 16'h0002;
    tick();
    chk("t4_mask_hold_valid", 32'(f_if.valid), 32'h1);
    chk("t4_mask_hold_code",  32'(f_if.code),  32'd1);
    f_if.mask = 16'h0000;
    f_if.ack  = 1'b1;
    tick();
    chk("t4_bubble",  32'(f_if.valid),   32'h0);
    chk("t4_pending", 32'(f_if.pending), 32'h0001);
    tick();
    chk("t4_valid2", 32'(f_if.valid), 32'h1);
    chk("t4_code2",  32'(f_if.code),  32'd0);
    tick();
    f_if.ack = 1'b0;
    f_if.req = 16'h0;
    tick();

    // Test 5: overrun on repeated rises, re-rise in the ack cycle
    f_if.req = 16'h0010;
    q_f.push_back(4'd4);
    q_f.push_back(4'd4);
    tick();
    chk("t5_pending", 32'(f_if.pending), 32'h0010);
    chk("t5_ovr0",    32'(f_if.overrun), 32'h0);
    f_if.req = 16'h0;
    tick();
    chk("t5_code", 32'(f_if.code), 32'd4);
    for (int k = 0; k < 2; k++) begin
      f_if.req = 16'h0010;
      tick();
      chk("t5_ovr_pulse", 32'(f_if.overrun), 32'h1);
      chk("t5_pend_keep", 32'(f_if.pending), 32'h0010);
      f_if.req = 16'h0;
      tick();
      chk("t5_ovr_low", 32'(f_if.overrun), 32'h0);
    end
    f_if.req = 16'h0010;
    f_if.ack = 1'b1;
    tick();
    chk("t5_setclr_pending", 32'(f_if.pending), 32'h0010);
    chk("t5_setclr_ovr",     32'(f_if.overrun), 32'h0);
    chk("t5_setclr_valid",   32'(f_if.valid),   32'h0);
    f_if.ack = 1'b0;
    f_if.req = 16'h0;
    tick();
    chk("t5_reoffer_valid", 32'(f_if.valid), 32'h1);
    chk("t5_reoffer_code",  32'(f_if.code),  32'd4);
    f_if.ack = 1'b1;
    tick();
    chk("t5_final_pending", 32'(f_if.pending), 32'h0);
    f_if.ack = 1'b0;
    tick();

    // Test 3: round-robin instance
    r_if.req = 16'h0204;
    q_r.push_back(4'd2);
    q_r.push_back(4'd9);
    q_r.push_back(4'd2);
    tick();
    chk("t3_pending", 32'(r_if.pending), 32'h0204);
    r_if.req = 16'h0;
    tick();
    chk("t3_code_a", 32'(r_if.code), 32'd2);
    r_if.req = 16'h0004;
    r_if.ack = 1'b1;
    tick();
    chk("t3_pending_b", 32'(r_if.pending), 32'h0204);
    r_if.req = 16'h0;
    r_if.ack = 1'b0;
    tick();
    chk("t3_valid_b", 32'(r_if.valid), 32'h1);
    chk("t3_code_b",  32'(r_if.code),  32'd9);
    r_if.ack = 1'b1;
    tick();
    r_if.ack = 1'b0;
    tick();
    chk("t3_code_c", 32'(r_if.code), 32'd2);
    r_if.ack = 1'b1;
    tick();
    r_if.ack = 1'b0;
    chk("t3_pending_end", 32'(r_if.pending), 32'h0);
    tick();

    // Test 6: asynchronous reset mid-offer
    f_if.req = 16'h0020;
    tick();
    tick();
    chk("t6_offer", 32'(f_if.valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid",   32'(f_if.valid),   32'h0);
    chk("t6_code",    32'(f_if.code),    32'h0);
    chk("t6_pending", 32'(f_if.pending), 32'h0);
    f_if.req = 16'h0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    chk("queue_fixed_drained", 32'(q_f.size()), 32'h0);
    chk("queue_rr_drained",    32'(q_r.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
